instr_mem_responder: RTL
========================

// Module: instr_mem_responder
// PURPOSE
//  Responder end of the instruction-fetch bus (req/gnt/addr/rdata/err/rvalid).
//  Word-addressed instruction SRAM answering the fetch stage's requests in order,
//  with a fixed read latency and a bounded number of outstanding requests.
//  Sits between the fetch stage and the boot/test loader; the loader fills it
//  through a side write port.
// PARAMETERS
//  MEM_WORDS        1024  number of 32-bit words stored
//  BASE_ADDR        0     byte address of word 0
//  LATENCY          1     cycles from accepting cycle to rvalid (1..MAX_LATENCY)
//  NUM_OUTSTANDING  2     max accepted-but-unanswered requests (1..4)
// PORTS
//  clk             in   1   clock
//  rstn            in   1   async active-low reset
//  instr_req_i     in   1   fetch request
//  instr_gnt_o     out  1   request accepted this cycle (combinational)
//  instr_addr_i    in   32  byte address; bits [1:0] ignored
//  instr_rdata_o   out  32  returned word, valid with rvalid
//  instr_err_o     out  1   access error, valid with rvalid
//  instr_rvalid_o  out  1   response strobe, one per accepted request
//  gnt_block_i     in   1   forces gnt low (backpressure injection)
//  load_we_i       in   1   loader write strobe
//  load_addr_i     in   32  loader byte address
//  load_wdata_i    in   32  loader write data
// BEHAVIOUR
//  - Reset: rvalid=0, rdata=0, err=0, outstanding count=0, all delay-line valids
//    cleared. Memory array is not reset. In-flight requests are dropped, never
//    answered after reset release.
//  - gnt = req & ~gnt_block & ((count - rvalid) < NUM_OUTSTANDING). A slot freed
//    by a response in the same cycle is reusable in that cycle. gnt is 0 while
//    rstn is low.
//  - Accept (req&gnt): word index and error flag enter a LATENCY-deep delay line.
//    rvalid is high exactly LATENCY cycles later. Order is strictly FIFO.
//    Back-to-back accepts give back-to-back responses.
//  - count: +1 on accept, -1 on rvalid, unchanged when both occur.
//    Never exceeds NUM_OUTSTANDING and never underflows (assertion).
//  - Index = (addr - BASE_ADDR) >> 2, width clog2(MEM_WORDS).
//  - Array read happens in the accept cycle. A loader write to the same word in
//    that cycle is not seen: the response carries the old data.
//  - Loader write always has priority over nothing; it never stalls gnt.
//  - rdata is held at the last value when rvalid is low.
// CONFIGURATION
//  INSTR_MEM_RANGE_CHECK_EN defined:
//    - Address outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS): the response has
//      err=1 and rdata=0, with normal latency.
//    - Out-of-range loader writes are discarded.
//  Undefined:
//    - err is tied to 0.
//    - Index wraps modulo MEM_WORDS (aliasing), for both reads and loader writes.
// STRUCTURE
//  - Package instr_mem_pkg:
//    - MAX_LATENCY=4 and MAX_OUTSTANDING=4
//    - typedef instr_rsp_t {logic [31:0] rdata; logic err;}
//    - typedef for the delay-line stage {logic valid; instr_rsp_t rsp;}
//  - Sub-module instr_mem_delay_line:
//    - parameterised LATENCY shift register of stage structs, async reset of
//      the valid bits only.
//  - Top holds the array, the outstanding counter and the gnt logic.
// TESTING
//  1. LATENCY=1, mem[0]=32'h00000013, req addr 0x0
//     -> gnt same cycle; next cycle rvalid=1, rdata=32'h00000013, err=0.
//  2. LATENCY=3, N=2, req held, addr 0x0,0x4,0x8
//     -> gnt at c0,c1; low at c2; rvalid at c3 with gnt for 0x8 in c3; third
//        rvalid at c6.
//  3. gnt_block_i=1 for 3 cycles with req=1
//     -> gnt=0 and no rvalid in those cycles; first accept on release; rvalid
//        LATENCY later.
//  4. Req at BASE_ADDR + 4*MEM_WORDS
//     -> with _EN: rvalid, err=1, rdata=0.
//     -> without: err=0, rdata=mem[0].
//  5. Two requests in flight, rstn pulsed low one cycle
//     -> no rvalid ever for them; count=0; new req is granted immediately.
//  6. load_we to word 5 (data A) in the same cycle as accept of 0x14
//     -> response is old data; a following read of 0x14 returns A.

Source files
------------

// File: rtl/instr_mem_responder_pkg.sv
// Shared types and limits for the instruction-memory responder.
package instr_mem_pkg;

  localparam int unsigned MAX_LATENCY     = 4;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } instr_rsp_t;

  typedef struct packed {
    logic       valid;
    instr_rsp_t rsp;
  } dl_stage_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch bus: fetch stage is master, memory responder is slave.
interface instr_mem_responder_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        instr_rvalid_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rdata_o, instr_err_o, instr_rvalid_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rdata_o, instr_err_o, instr_rvalid_o
  );
endinterface

// File: rtl/instr_mem_delay_line.sv
// Fixed-latency response pipe; only the valid bits are reset so in-flight
// responses vanish on reset while the data path stays reset-free.
module instr_mem_delay_line
  import instr_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk,
  input  logic      rstn,
  input  dl_stage_t stage_in,
  output dl_stage_t stage_out
);

  logic [LATENCY:1] vld_pipe;
  instr_rsp_t       rsp_pipe [1:LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= stage_in.valid;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rsp_pipe[1] <= stage_in.rsp;
    for (int i = 2; i <= LATENCY; i++) rsp_pipe[i] <= rsp_pipe[i-1];
  end

  assign stage_out.valid = vld_pipe[LATENCY];
  assign stage_out.rsp   = rsp_pipe[LATENCY];

endmodule

// File: rtl/instr_mem_responder.sv
// Word-addressed instruction SRAM behind the fetch bus, fixed read latency,
// bounded outstanding requests. Optional INSTR_MEM_RANGE_CHECK_EN flags
// out-of-range fetches with err and drops out-of-range loader writes.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned NUM_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  instr_mem_responder_if.slave  bus,
  input  logic                  gnt_block_i,
  input  logic                  load_we_i,
  input  logic [31:0]           load_addr_i,
  input  logic [31:0]           load_wdata_i
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] rd_idx, ld_idx;
  logic             rd_ok, ld_ok;
  logic             accept;
  logic [CNT_W-1:0] count_q, cnt_after_rsp;
  logic [31:0]      rdata_q;
  logic             err_q;
  dl_stage_t        dl_in, dl_out;

  // Truncation to IDX_W gives modulo-MEM_WORDS aliasing (MEM_WORDS is a power of two).
  assign rd_idx = IDX_W'((bus.instr_addr_i - BASE_ADDR) >> 2);
  assign ld_idx = IDX_W'((load_addr_i - BASE_ADDR) >> 2);

`ifdef INSTR_MEM_RANGE_CHECK_EN
  // Unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
  assign rd_ok = (bus.instr_addr_i - BASE_ADDR) < 32'(4 * MEM_WORDS);
  assign ld_ok = (load_addr_i - BASE_ADDR) < 32'(4 * MEM_WORDS);
`else
  assign rd_ok = 1'b1;
  assign ld_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (load_we_i && ld_ok) mem[ld_idx] <= load_wdata_i;
  end

  // A response leaving this cycle frees its slot for a request in the same cycle.
  assign cnt_after_rsp   = count_q - CNT_W'(dl_out.valid);
  assign bus.instr_gnt_o = rstn & bus.instr_req_i & ~gnt_block_i
                         & (cnt_after_rsp < CNT_W'(NUM_OUTSTANDING));
  assign accept          = bus.instr_req_i & bus.instr_gnt_o;

  // Array is read combinationally in the accept cycle: a same-cycle loader write is not seen.
  assign dl_in.valid     = accept;
  assign dl_in.rsp.rdata = rd_ok ? mem[rd_idx] : 32'h0;
  assign dl_in.rsp.err   = ~rd_ok;

  instr_mem_delay_line #(.LATENCY(LATENCY)) u_dl (
    .clk       (clk),
    .rstn      (rstn),
    .stage_in  (dl_in),
    .stage_out (dl_out)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_q + CNT_W'(accept) - CNT_W'(dl_out.valid);
      if (dl_out.valid) begin
        rdata_q <= dl_out.rsp.rdata;
        err_q   <= dl_out.rsp.err;
      end
    end
  end

  assign bus.instr_rvalid_o = dl_out.valid;
  assign bus.instr_rdata_o  = dl_out.valid ? dl_out.rsp.rdata : rdata_q;
  assign bus.instr_err_o    = dl_out.valid ? dl_out.rsp.err   : err_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(dl_out.valid && count_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    count_q <= CNT_W'(NUM_OUTSTANDING));

endmodule
